// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes and controller states.
package lsu_pkg;

    localparam logic [1:0] LSU_SZ_B = 2'd0;
    localparam logic [1:0] LSU_SZ_H = 2'd1;
    localparam logic [1:0] LSU_SZ_W = 2'd2;
    localparam logic [1:0] LSU_SZ_D = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for lsu_ctrl: store strobe/data placement and load extraction
// with sign or zero extension. Purely combinational.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [1:0]                 i_size,
    input  logic [$clog2(XLEN/8)-1:0]  i_off,
    input  logic                       i_unsigned,
    input  logic [XLEN-1:0]            i_wdata,
    input  logic [XLEN-1:0]            i_rdata,
    output logic [XLEN/8-1:0]          o_wstrb,
    output logic [XLEN-1:0]            o_wdata,
    output logic [XLEN-1:0]            o_ldata
);

    localparam int NB = XLEN / 8;

    logic [4:0]      w_nbytes;
    logic [NB-1:0]   w_base;
    logic [XLEN-1:0] w_keep;
    logic [XLEN-1:0] w_raw;
    logic            w_sign;

    assign w_nbytes = 5'd1 << i_size;

    // w_base marks the low nbytes lanes; w_keep widens it to a bit mask.
    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
            assign w_base[gi]         = (w_nbytes > 5'(gi));
            assign w_keep[8*gi +: 8]  = {8{w_base[gi]}};
        end
    endgenerate

    assign o_wstrb = w_base << i_off;
    assign o_wdata = i_wdata << {i_off, 3'b000};
    assign w_raw   = i_rdata >> {i_off, 3'b000};

    always_comb begin
        w_sign = w_raw[XLEN-1];
        case (i_size)
            LSU_SZ_B: w_sign = w_raw[7];
            LSU_SZ_H: w_sign = w_raw[15];
            LSU_SZ_W: w_sign = w_raw[31];
            default:  w_sign = w_raw[XLEN-1];
        endcase
    end

    // Full-width accesses have an all-ones keep mask, so they pass through untouched.
    assign o_ldata = (w_raw & w_keep) | ((w_sign && !i_unsigned) ? ~w_keep : '0);

endmodule

// File: rtl/lsu_ctrl.sv
// Multi-cycle load/store unit: one access at a time over a request/response memory port.
// Define LSU_MISALIGN_TRAP_EN to report misaligned accesses instead of force-aligning them.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 64
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic                req_write,
    input  logic [1:0]          req_size,
    input  logic                req_unsigned,
    input  logic [XLEN-1:0]     req_wdata,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [XLEN-1:0]     resp_rdata,
    output logic                resp_err,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [XLEN-1:0]     mem_wdata,
    output logic [XLEN/8-1:0]   mem_wstrb,
    input  logic                mem_rsp_valid,
    input  logic [XLEN-1:0]     mem_rsp_rdata
);

    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);

    lsu_state_t        r_state;
    logic              r_req_ready, r_mem_req_valid, r_mem_wen, r_resp_valid;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [XLEN-1:0]   r_mem_wdata, r_resp_rdata;
    logic [NB-1:0]     r_mem_wstrb;
    logic [1:0]        r_size;
    logic [OFFW-1:0]   r_off;
    logic              r_unsigned;

    logic [1:0]        w_size, w_al_size;
    logic [2:0]        w_lowmask;
    logic [ADDR_W-1:0] w_addr_al;
    logic [OFFW-1:0]   w_off, w_al_off;
    logic [NB-1:0]     w_strb;
    logic [XLEN-1:0]   w_wdata_sh, w_ldata;

    // A doubleword on a 32-bit datapath collapses to a word.
    assign w_size = (XLEN == 32 && req_size == LSU_SZ_D) ? LSU_SZ_W : req_size;

    always_comb begin
        w_lowmask = 3'd7;
        case (w_size)
            LSU_SZ_B: w_lowmask = 3'd0;
            LSU_SZ_H: w_lowmask = 3'd1;
            LSU_SZ_W: w_lowmask = 3'd3;
            default:  w_lowmask = 3'd7;
        endcase
    end

    assign w_addr_al = req_addr & ~{{(ADDR_W-3){1'b0}}, w_lowmask};
    assign w_off     = w_addr_al[OFFW-1:0];

`ifdef LSU_MISALIGN_TRAP_EN
    logic w_misaligned;
    logic r_resp_err;
    assign w_misaligned = |(req_addr[2:0] & w_lowmask);
    assign resp_err     = r_resp_err;
`else
    assign resp_err     = 1'b0;
`endif

    // The steering block serves the incoming request in IDLE and the latched one afterwards.
    assign w_al_size = (r_state == IDLE) ? w_size : r_size;
    assign w_al_off  = (r_state == IDLE) ? w_off  : r_off;

    lsu_align #(.XLEN(XLEN)) u_align (
        .i_size     (w_al_size),
        .i_off      (w_al_off),
        .i_unsigned (r_unsigned),
        .i_wdata    (req_wdata),
        .i_rdata    (mem_rsp_rdata),
        .o_wstrb    (w_strb),
        .o_wdata    (w_wdata_sh),
        .o_ldata    (w_ldata)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= IDLE;
            r_req_ready     <= 1'b1;
            r_mem_req_valid <= 1'b0;
            r_mem_wen       <= 1'b0;
            r_resp_valid    <= 1'b0;
            r_mem_addr      <= '0;
            r_mem_wdata     <= '0;
            r_mem_wstrb     <= '0;
            r_resp_rdata    <= '0;
            r_size          <= LSU_SZ_B;
            r_off           <= '0;
            r_unsigned      <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            r_resp_err      <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: if (req_valid) begin
                    r_req_ready <= 1'b0;
                    r_size      <= w_size;
                    r_off       <= w_off;
                    r_unsigned  <= req_unsigned;
`ifdef LSU_MISALIGN_TRAP_EN
                    if (w_misaligned) begin
                        r_state      <= RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b1;
                        r_resp_rdata <= '0;
                    end else
`endif
                    begin
                        r_state         <= REQ;
                        r_mem_req_valid <= 1'b1;
                        r_mem_addr      <= {w_addr_al[ADDR_W-1:OFFW], {OFFW{1'b0}}};
                        r_mem_wen       <= req_write;
                        r_mem_wstrb     <= w_strb;
                        r_mem_wdata     <= w_wdata_sh;
                    end
                end
                REQ: if (mem_req_ready) begin
                    r_mem_req_valid <= 1'b0;
                    r_state         <= WAIT;
                end
                WAIT: if (mem_rsp_valid) begin
                    r_resp_rdata <= r_mem_wen ? '0 : w_ldata;
                    r_resp_valid <= 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
                    r_resp_err   <= 1'b0;
`endif
                    r_state      <= RESP;
                end
                RESP: if (resp_ready) begin
                    r_resp_valid <= 1'b0;
                    r_req_ready  <= 1'b1;
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready     = r_req_ready;
    assign resp_valid    = r_resp_valid;
    assign resp_rdata    = r_resp_rdata;
    assign mem_req_valid = r_mem_req_valid;
    assign mem_addr      = r_mem_addr;
    assign mem_wen       = r_mem_wen;
    assign mem_wdata     = r_mem_wdata;
    assign mem_wstrb     = r_mem_wstrb;

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Multi-cycle load/store unit for the NPC core, replacing the combinational single-cycle memory access path. It accepts one load or store from the execute stage over a valid/ready handshake and issues a single aligned, byte-strobed transaction on a request/response memory port. It returns sign- or zero-extended load data to the pipeline. Data width is parametrised, and misaligned accesses are detected.

## Interface
- `XLEN`, default 64: datapath width in bits; legal values are 32 and 64.
- `ADDR_W`, default 64: address width in bits.
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset_n` in 1: asynchronous assert, active-low reset.
- `req_valid` in 1: execute stage presents an access.
- `req_ready` out 1: unit can accept an access.
- `req_addr` in ADDR_W: byte address.
- `req_write` in 1: 1 = store, 0 = load.
- `req_size` in 2: access size; 0 = byte, 1 = half, 2 = word, 3 = double (3 is legal only when XLEN = 64).
- `req_unsigned` in 1: zero-extend load data instead of sign-extending.
- `req_wdata` in XLEN: store data, right-justified.
- `resp_valid` out 1: result available.
- `resp_ready` in 1: pipeline consumes the result.
- `resp_rdata` out XLEN: extended load data; 0 for stores and errors.
- `resp_err` out 1: access was misaligned (meaningful only when `LSU_MISALIGN_TRAP_EN` is defined).
- `mem_req_valid` out 1: memory request valid.
- `mem_req_ready` in 1: memory accepts the request.
- `mem_addr` out ADDR_W: `req_addr` with its low log2(XLEN/8) bits cleared.
- `mem_wen` out 1: request is a write.
- `mem_wdata` out XLEN: store data shifted to its byte lanes.
- `mem_wstrb` out XLEN/8: byte-enable strobe; also driven for reads.
- `mem_rsp_valid` in 1: read data or write acknowledge returned.
- `mem_rsp_rdata` in XLEN: full-width read data.

## Operation
- States:
  - IDLE: `req_ready` = 1. On `req_valid`, latch all request fields and go to REQ. With the trap macro defined and the access misaligned, go to RESP instead.
  - REQ: `mem_req_valid` = 1. On `mem_req_ready`, go to WAIT.
  - WAIT: on `mem_rsp_valid`, capture the extended result and go to RESP. `mem_rsp_valid` is ignored in every other state.
  - RESP: `resp_valid` = 1. On `resp_ready`, go to IDLE.
- Sizing and lane placement:
  - nbytes = 1 << size.
  - off = addr[log2(XLEN/8)-1:0].
  - `mem_wstrb` = ((1 << nbytes) - 1) << off.
  - `mem_wdata` = wdata << (8*off).
- Load result:
  - raw = `mem_rsp_rdata` >> (8*off), truncated to nbytes.
  - Extended to XLEN by sign bit raw[8*nbytes-1], or with zeros when `req_unsigned` = 1.
  - size = 3 (or size = 2 when XLEN = 32) passes the data through unchanged, whatever `req_unsigned` is.
- Misaligned definition: (addr mod nbytes) != 0.
- `req_size` = 3 with XLEN = 32 is treated as size 2.
- Stores return `resp_rdata` = 0 and `resp_err` = 0 once `mem_rsp_valid` is seen.
- Only one access is outstanding; there is no pipelining across requests.

## Timing
- Reset values: state IDLE; `req_ready` = 1; `resp_valid`, `resp_err`, `mem_req_valid`, `mem_wen` = 0; all data, address and strobe outputs = 0.
- `reset_n` low in any state aborts the access immediately. No response is produced, and a memory response arriving later is ignored.
- Minimum latency, counting request acceptance as cycle 0:
  - cycle 1: `mem_req_valid` asserted.
  - cycle 2: earliest cycle `mem_rsp_valid` is sampled.
  - cycle 3: `resp_valid` asserted.
- Misaligned trap path: `resp_valid` is asserted in cycle 1 with no memory traffic.
- `mem_*` request outputs and `resp_*` outputs are registered, and stay stable while their valid is held without the matching ready.
- Memory must not assert `mem_rsp_valid` in the same cycle as the `mem_req_ready` handshake.
- `req_ready` is low in REQ, WAIT and RESP. A new request is accepted only the cycle after the RESP handshake.

## Configuration
- Macro: `LSU_MISALIGN_TRAP_EN`.
- Defined:
  - A misaligned access produces `resp_err` = 1 and `resp_rdata` = 0.
  - No memory request is issued and memory state is unchanged.
- Undefined:
  - Misalignment is not checked; the address is forced to natural alignment by clearing addr bits below log2(nbytes).
  - `resp_err` is tied to 0.

## Structure
- Package `lsu_pkg` holds:
  - size encodings `LSU_SZ_B/H/W/D`;
  - the state enum `lsu_state_t` (IDLE, REQ, WAIT, RESP).
- Sub-module `lsu_align`, purely combinational, handles byte-lane steering: generation of `mem_wstrb`/`mem_wdata` and load extraction/extension.
- `lsu_ctrl` holds the FSM, the request latch and the response register.

## Test plan
- Load byte, XLEN = 64, addr 0x8000_0003, unsigned = 0, memory returns 0x0000_0000_8000_0000:
  - `mem_addr` = 0x8000_0000, `mem_wstrb` = 0x08;
  - `resp_rdata` = 0xFFFF_FFFF_FFFF_FF80 on the first RESP cycle, which is cycle 3.
- Same as above with unsigned = 1:
  - `resp_rdata` = 0x0000_0000_0000_0080.
- Store half, addr 0x8000_0006, wdata 0x1234, `mem_req_ready` delayed by 4 cycles:
  - `mem_wstrb` = 0xC0 and `mem_wdata` = 0x1234_0000_0000_0000, both held stable while waiting;
  - `resp_rdata` = 0.
- Load word at 0x8000_0002 with the trap macro defined:
  - `resp_valid` = 1 and `resp_err` = 1 in cycle 1;
  - `mem_req_valid` never rises.
- Same access with the macro undefined:
  - `mem_addr` = 0x8000_0000, `mem_wstrb` = 0x0F, `resp_err` = 0.
- `reset_n` pulled low in WAIT, with `mem_rsp_valid` arriving 2 cycles after release:
  - outputs return to their reset values;
  - no `resp_valid`;
  - the next request completes normally.
